// File: rtl/cw_mux_sel_ctrl.sv
// Display-mode controller: debounces the mode/back buttons and drives the one-hot 3:1 mux select.
// Optional feature macro CW_MODE_TIMEOUT_EN builds the auto-return-to-TIME timeout on tick_1hz.
module cw_mux_sel_ctrl #(
    parameter int DB_COUNT    = 50000,
    parameter int DB_W        = 16,
    parameter int TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_back,
    input  logic       force_time,
    output logic [2:0] sel,
    output logic       mode_chg
);
    typedef enum logic [1:0] {
        ST_TIME  = 2'd0,
        ST_ALARM = 2'd1,
        ST_DATE  = 2'd2
    } state_t;

    // Button vectors: bit 0 = mode, bit 1 = back.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      db_q;
    logic [1:0]      db_prev_q;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt_q [2];

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] sel_q;
    logic [2:0] sel_d;
    logic       mode_chg_q;
    logic       mode_chg_d;
    logic       state_legal;
    logic       expire;

    assign btn_raw = {btn_back, btn_mode};
    assign press   = db_q & ~db_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DB_COUNT - 1)) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign state_legal = (state_q == ST_TIME) || (state_q == ST_ALARM) || (state_q == ST_DATE);

`ifdef CW_MODE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;

    assign expire = (state_q != ST_TIME) && tick_1hz && (tmo_q == TW'(TIMEOUT_SEC - 1));

    always_comb begin
        tmo_d = tmo_q;
        if ((state_d != state_q) || (|press) || (state_q == ST_TIME)) begin
            tmo_d = '0;
        end else if (tick_1hz && (tmo_q != TW'(TIMEOUT_SEC - 1))) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    localparam int UNUSED_TIMEOUT_SEC = TIMEOUT_SEC;
    logic unused_tick;

    assign unused_tick = tick_1hz;
    assign expire      = 1'b0;
`endif

    // Priority: force_time, back, mode, timeout; an illegal encoding always lands in TIME.
    always_comb begin
        state_d = state_q;
        if (force_time) begin
            state_d = ST_TIME;
        end else if (press[1]) begin
            state_d = ST_TIME;
        end else if (press[0]) begin
            case (state_q)
                ST_TIME:  state_d = ST_ALARM;
                ST_ALARM: state_d = ST_DATE;
                default:  state_d = ST_TIME;
            endcase
        end else if (expire) begin
            state_d = ST_TIME;
        end
        if (!state_legal) begin
            state_d = ST_TIME;
        end

        case (state_d)
            ST_ALARM: sel_d = 3'b010;
            ST_DATE:  sel_d = 3'b001;
            default:  sel_d = 3'b100;
        endcase
        mode_chg_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TIME;
            sel_q      <= 3'b100;
            mode_chg_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    assign sel      = sel_q;
    assign mode_chg = mode_chg_q;

endmodule
